// File: rtl/minimac2_pkg.sv
// minimac2 shared definitions: receive FSM encoding, MII nibble constants, slot address width.
// Latency: none (constants only).
// Backpressure: not applicable.
package minimac2_pkg;

  // Slot RAM address width; also the width of the byte counter and count outputs.
  localparam int ADR_W = 11;

  // Receive FSM encoding, kept as plain vectors for older tools.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_RECEIVE  = 2'd2;
  localparam logic [1:0] ST_DISCARD  = 2'd3;

  // Preamble nibble and start-of-frame-delimiter nibble as seen on MII (low nibble first).
  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

endpackage

// File: rtl/minimac2_rx_if.sv
// minimac2 receive bundle: MII pins, slot arm/done handshake, slot RAM write ports.
// Latency: none (wiring only).
// Backpressure: none; software re-arms slots through rx_ready pulses.
interface minimac2_rx_if;

  logic [1:0]                     rx_ready;
  logic [1:0]                     rx_done;
  logic [minimac2_pkg::ADR_W-1:0] rx_count_0;
  logic [minimac2_pkg::ADR_W-1:0] rx_count_1;
  logic [minimac2_pkg::ADR_W-1:0] rxb0_adr;
  logic [minimac2_pkg::ADR_W-1:0] rxb1_adr;
  logic [7:0]                     rxb0_dat;
  logic [7:0]                     rxb1_dat;
  logic                           rxb0_we;
  logic                           rxb1_we;
  logic [3:0]                     phy_rx_data;
  logic                           phy_dv;
  logic                           phy_rx_er;

  // Driver side: PHY model and software.
  modport master (
    output rx_ready, phy_rx_data, phy_dv, phy_rx_er,
    input  rx_done, rx_count_0, rx_count_1,
    input  rxb0_adr, rxb1_adr, rxb0_dat, rxb1_dat, rxb0_we, rxb1_we
  );

  // Receive engine side.
  modport slave (
    input  rx_ready, phy_rx_data, phy_dv, phy_rx_er,
    output rx_done, rx_count_0, rx_count_1,
    output rxb0_adr, rxb1_adr, rxb0_dat, rxb1_dat, rxb0_we, rxb1_we
  );

endinterface

// File: rtl/minimac2_rx_slot.sv
// minimac2 receive slot: armed flag, completion count latch, one-cycle done pulse.
// Latency: done and count register 1 cycle after complete; avail drops in the same cycle done rises.
// Backpressure: none; a completion always clears avail, even against a simultaneous arm.
module minimac2_rx_slot
  import minimac2_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_arm,
  input  logic             i_complete,
  input  logic [ADR_W-1:0] i_count,
  output logic             o_avail,
  output logic             o_done,
  output logic [ADR_W-1:0] o_count
);

  logic             r_avail;
  logic             r_done;
  logic [ADR_W-1:0] r_count;

  // Track arming, pulse done and latch the count only on completion so count stays stable between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_avail <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= i_complete;
      if (i_complete) begin
        r_avail <= 1'b0;
        r_count <= i_count;
      end else if (i_arm) begin
        r_avail <= 1'b1;
      end
    end
  end

  assign o_avail = r_avail;
  assign o_done  = r_done;
  assign o_count = r_count;

endmodule

// File: rtl/minimac2_rx.sv
// minimac2 receive engine: strips preamble/SFD, packs MII nibbles into bytes, writes the armed slot RAM.
// Latency: byte write 2 clocks after its high nibble on the pins; rx_done 2 clocks after dv falls on the pins.
// Backpressure: none; frames with no armed slot, MII errors or overlength are dropped without done.
module minimac2_rx
  import minimac2_pkg::*;
#(
  parameter int RX_MAX = 2047
) (
  input  logic         phy_rx_clk,
  input  logic         phy_rx_rst,
  minimac2_rx_if.slave rx
);

  localparam logic [ADR_W-1:0] MAX_CNT = ADR_W'(RX_MAX);

  logic [3:0]       r_rx_data;
  logic             r_dv;
  logic             r_dv_d;
  logic             r_er;
  logic [1:0]       r_state;
  logic             r_sel;
  logic [ADR_W-1:0] r_cnt;
  logic [3:0]       r_lo;
  logic             r_phase;
  logic [ADR_W-1:0] r_adr;
  logic [7:0]       r_dat;
  logic             r_we0;
  logic             r_we1;

  logic             w_dv_rise;
  logic             w_complete;
  logic [1:0]       w_avail;
  logic [1:0]       w_done;
  logic [ADR_W-1:0] w_count0;
  logic [ADR_W-1:0] w_count1;

  // Register the MII pins once; r_dv_d gives the previous dv for frame-start edge detection.
  always_ff @(posedge phy_rx_clk) begin
    if (phy_rx_rst) begin
      r_rx_data <= 4'h0;
      r_dv      <= 1'b0;
      r_dv_d    <= 1'b0;
      r_er      <= 1'b0;
    end else begin
      r_rx_data <= rx.phy_rx_data;
      r_dv      <= rx.phy_dv;
      r_dv_d    <= r_dv;
      r_er      <= rx.phy_rx_er;
    end
  end

  assign w_dv_rise  = r_dv & ~r_dv_d;
  // A clean end of a non-empty frame; the slot registers it so done lands one cycle later.
  assign w_complete = (r_state == ST_RECEIVE) && !r_er && !r_dv && (r_cnt != '0);

  // Frame FSM: slot selection, preamble strip, nibble assembly and slot RAM writes.
  always_ff @(posedge phy_rx_clk) begin
    if (phy_rx_rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
      r_lo    <= 4'h0;
      r_phase <= 1'b0;
      r_adr   <= '0;
      r_dat   <= 8'h00;
      r_we0   <= 1'b0;
      r_we1   <= 1'b0;
    end else begin
      r_we0 <= 1'b0;
      r_we1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_dv_rise) begin
            if (w_avail[0]) begin
              r_state <= ST_PREAMBLE;
              r_sel   <= 1'b0;
            end else if (w_avail[1]) begin
              r_state <= ST_PREAMBLE;
              r_sel   <= 1'b1;
            end else begin
              r_state <= ST_DISCARD;
            end
          end
        end
        ST_PREAMBLE: begin
          if (r_er || !r_dv) begin
            r_state <= ST_DISCARD;
          end else if (r_rx_data == NIB_SFD) begin
            r_state <= ST_RECEIVE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
          end else if (r_rx_data != NIB_PRE) begin
            r_state <= ST_DISCARD;
          end
        end
        ST_RECEIVE: begin
          if (r_er) begin
            r_state <= ST_DISCARD;
          end else if (!r_dv) begin
            // Completion (if any) is signalled through w_complete; a dangling low nibble is dropped.
            r_state <= ST_IDLE;
          end else if (!r_phase) begin
            r_lo    <= r_rx_data;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (r_cnt == MAX_CNT) begin
              // This byte would push the frame past RX_MAX: drop it and the rest of the frame.
              r_state <= ST_DISCARD;
            end else begin
              r_adr <= r_cnt;
              r_dat <= {r_rx_data, r_lo};
              r_we0 <= ~r_sel;
              r_we1 <= r_sel;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          if (!r_dv) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  minimac2_rx_slot u_slot0 (
    .clk        (phy_rx_clk),
    .rst        (phy_rx_rst),
    .i_arm      (rx.rx_ready[0]),
    .i_complete (w_complete & ~r_sel),
    .i_count    (r_cnt),
    .o_avail    (w_avail[0]),
    .o_done     (w_done[0]),
    .o_count    (w_count0)
  );

  minimac2_rx_slot u_slot1 (
    .clk        (phy_rx_clk),
    .rst        (phy_rx_rst),
    .i_arm      (rx.rx_ready[1]),
    .i_complete (w_complete & r_sel),
    .i_count    (r_cnt),
    .o_avail    (w_avail[1]),
    .o_done     (w_done[1]),
    .o_count    (w_count1)
  );

  assign rx.rx_done    = w_done;
  assign rx.rx_count_0 = w_count0;
  assign rx.rx_count_1 = w_count1;
  assign rx.rxb0_adr   = r_adr;
  assign rx.rxb1_adr   = r_adr;
  assign rx.rxb0_dat   = r_dat;
  assign rx.rxb1_dat   = r_dat;
  assign rx.rxb0_we    = r_we0;
  assign rx.rxb1_we    = r_we1;

endmodule

// File: tb/tb_minimac2_rx.sv
// Directed bench for minimac2_rx: MII frames in, slot RAM writes / done pulses / counts observed.
// Latency: checks first-write and done timing against pin activity.
// Backpressure: not applicable.
module tb_minimac2_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int vectors     = 0;
  int miscompares = 0;

  int wr_cnt0, wr_cnt1, done_cnt0, done_cnt1, adr_err0, adr_err1;
  int t_we0, t_done0, t_hi, t_dvlow;
  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];
  logic [1:0] done_log [$];

  minimac2_rx_if bus ();

  minimac2_rx #(.RX_MAX(2047)) dut (
    .phy_rx_clk (clk),
    .phy_rx_rst (rst),
    .rx         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record slot RAM writes and done pulses half a cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.rxb0_we) begin
      if (bus.rxb0_adr !== wr_cnt0[10:0]) adr_err0++;
      if (wr_cnt0 == 0) t_we0 = cyc;
      mem0[bus.rxb0_adr] = bus.rxb0_dat;
      wr_cnt0++;
    end
    if (bus.rxb1_we) begin
      if (bus.rxb1_adr !== wr_cnt1[10:0]) adr_err1++;
      mem1[bus.rxb1_adr] = bus.rxb1_dat;
      wr_cnt1++;
    end
    if (bus.rx_done[0]) begin
      if (done_cnt0 == 0) t_done0 = cyc;
      done_cnt0++;
    end
    if (bus.rx_done[1]) done_cnt1++;
    if (bus.rx_done != 2'b00) done_log.push_back(bus.rx_done);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic clr();
    wr_cnt0 = 0; wr_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    adr_err0 = 0; adr_err1 = 0; t_we0 = -1; t_done0 = -1;
    done_log.delete();
    for (int k = 0; k < 2048; k++) begin
      mem0[k] = 8'hxx;
      mem1[k] = 8'hxx;
    end
  endtask

  task automatic nib(input logic [3:0] n, input logic er);
    bus.phy_dv = 1'b1; bus.phy_rx_data = n; bus.phy_rx_er = er;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    bus.phy_dv = 1'b0; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 4'h0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic tx_byte(input logic [7:0] b, input logic er);
    nib(b[3:0], er);
    nib(b[7:4], er);
  endtask

  task automatic tx_head(input bit bad_sfd);
    repeat (7) tx_byte(8'h55, 1'b0);
    tx_byte(bad_sfd ? 8'h57 : 8'hD5, 1'b0);
  endtask

  // Full frame: preamble, SFD, n payload bytes seed, seed+1, ...; er during byte er_at; gap idle cycles.
  task automatic send_frame(input int n, input logic [7:0] seed, input int er_at, input bit bad_sfd,
                            input int gap);
    tx_head(bad_sfd);
    for (int k = 0; k < n; k++) begin
      tx_byte(8'(seed + 8'(k)), (k == er_at));
      if (k == 0) t_hi = cyc;
    end
    idle(1);
    t_dvlow = cyc;
    if (gap > 1) idle(gap - 1);
  endtask

  task automatic arm(input logic [1:0] m);
    bus.rx_ready = m;
    @(posedge clk); #1;
    bus.rx_ready = 2'b00;
  endtask

  task automatic test_reset();
    bus.rx_ready = 2'b00; bus.phy_dv = 1'b0; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 4'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.rx_done !== 2'b00) begin miscompares++; $display("FAIL reset_done: got %b want 00", bus.rx_done); end
    vectors++; if (bus.rxb0_we !== 1'b0) begin miscompares++; $display("FAIL reset_we0: got %b want 0", bus.rxb0_we); end
    vectors++; if (bus.rxb1_we !== 1'b0) begin miscompares++; $display("FAIL reset_we1: got %b want 0", bus.rxb1_we); end
    vectors++; if (bus.rx_count_0 !== 11'd0) begin miscompares++; $display("FAIL reset_count0: got %0d want 0", bus.rx_count_0); end
    vectors++; if (bus.rx_count_1 !== 11'd0) begin miscompares++; $display("FAIL reset_count1: got %0d want 0", bus.rx_count_1); end
    vectors++; if (bus.rxb0_adr !== 11'd0) begin miscompares++; $display("FAIL reset_adr: got %0d want 0", bus.rxb0_adr); end
    vectors++; if (bus.rxb0_dat !== 8'h00) begin miscompares++; $display("FAIL reset_dat: got %h want 00", bus.rxb0_dat); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_single();
    int errs;
    clr();
    arm(2'b01);
    send_frame(64, 8'h00, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 !== 64) begin miscompares++; $display("FAIL single_wr0: got %0d want 64", wr_cnt0); end
    vectors++; if (wr_cnt1 !== 0) begin miscompares++; $display("FAIL single_wr1: got %0d want 0", wr_cnt1); end
    vectors++; if (adr_err0 !== 0) begin miscompares++; $display("FAIL single_adr: got %0d bad addresses want 0", adr_err0); end
    errs = 0;
    for (int k = 0; k < 64; k++) if (mem0[k] !== 8'(k)) errs++;
    vectors++; if (errs !== 0) begin miscompares++; $display("FAIL single_data: got %0d bad bytes want 0", errs); end
    vectors++; if (done_log.size() !== 1 || done_log[0] !== 2'b01) begin miscompares++; $display("FAIL single_done: got %0d pulses want 1 of 01", done_log.size()); end
    vectors++; if (bus.rx_count_0 !== 11'd64) begin miscompares++; $display("FAIL single_count0: got %0d want 64", bus.rx_count_0); end
    vectors++; if (t_we0 !== t_hi + 1) begin miscompares++; $display("FAIL single_we_latency: got cycle %0d want %0d", t_we0, t_hi + 1); end
    vectors++; if (t_done0 !== t_dvlow + 1) begin miscompares++; $display("FAIL single_done_latency: got cycle %0d want %0d", t_done0, t_dvlow + 1); end
    // Slot 0 is no longer armed: a further frame must be dropped.
    clr();
    send_frame(20, 8'hA0, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 + wr_cnt1 !== 0) begin miscompares++; $display("FAIL single_avail_cleared: got %0d writes want 0", wr_cnt0 + wr_cnt1); end
    vectors++; if (done_cnt0 + done_cnt1 !== 0) begin miscompares++; $display("FAIL single_avail_done: got %0d done want 0", done_cnt0 + done_cnt1); end
  endtask

  task automatic test_back_to_back();
    int errs0, errs1;
    clr();
    arm(2'b11);
    send_frame(60, 8'h10, -1, 1'b0, 1);
    send_frame(60, 8'h80, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 !== 60) begin miscompares++; $display("FAIL b2b_wr0: got %0d want 60", wr_cnt0); end
    vectors++; if (wr_cnt1 !== 60) begin miscompares++; $display("FAIL b2b_wr1: got %0d want 60", wr_cnt1); end
    vectors++; if (adr_err0 + adr_err1 !== 0) begin miscompares++; $display("FAIL b2b_adr: got %0d bad addresses want 0", adr_err0 + adr_err1); end
    errs0 = 0; errs1 = 0;
    for (int k = 0; k < 60; k++) begin
      if (mem0[k] !== 8'(8'h10 + 8'(k))) errs0++;
      if (mem1[k] !== 8'(8'h80 + 8'(k))) errs1++;
    end
    vectors++; if (errs0 !== 0) begin miscompares++; $display("FAIL b2b_data0: got %0d bad bytes want 0", errs0); end
    vectors++; if (errs1 !== 0) begin miscompares++; $display("FAIL b2b_data1: got %0d bad bytes want 0", errs1); end
    vectors++; if (done_log.size() !== 2 || done_log[0] !== 2'b01 || done_log[1] !== 2'b10) begin miscompares++; $display("FAIL b2b_done_order: got %0d pulses want 01 then 10", done_log.size()); end
    vectors++; if (bus.rx_count_0 !== 11'd60) begin miscompares++; $display("FAIL b2b_count0: got %0d want 60", bus.rx_count_0); end
    vectors++; if (bus.rx_count_1 !== 11'd60) begin miscompares++; $display("FAIL b2b_count1: got %0d want 60", bus.rx_count_1); end
  endtask

  task automatic test_unarmed();
    int errs;
    clr();
    send_frame(40, 8'h22, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 + wr_cnt1 !== 0) begin miscompares++; $display("FAIL unarmed_wr: got %0d writes want 0", wr_cnt0 + wr_cnt1); end
    vectors++; if (done_log.size() !== 0) begin miscompares++; $display("FAIL unarmed_done: got %0d pulses want 0", done_log.size()); end
    clr();
    arm(2'b10);
    send_frame(100, 8'h33, -1, 1'b0, 6);
    vectors++; if (wr_cnt1 !== 100) begin miscompares++; $display("FAIL slot1_wr1: got %0d want 100", wr_cnt1); end
    vectors++; if (wr_cnt0 !== 0) begin miscompares++; $display("FAIL slot1_wr0: got %0d want 0", wr_cnt0); end
    errs = 0;
    for (int k = 0; k < 100; k++) if (mem1[k] !== 8'(8'h33 + 8'(k))) errs++;
    vectors++; if (errs !== 0) begin miscompares++; $display("FAIL slot1_data: got %0d bad bytes want 0", errs); end
    vectors++; if (done_log.size() !== 1 || done_log[0] !== 2'b10) begin miscompares++; $display("FAIL slot1_done: got %0d pulses want 1 of 10", done_log.size()); end
    vectors++; if (bus.rx_count_1 !== 11'd100) begin miscompares++; $display("FAIL slot1_count1: got %0d want 100", bus.rx_count_1); end
    vectors++; if (bus.rx_count_0 !== 11'd60) begin miscompares++; $display("FAIL slot1_count0_stable: got %0d want 60", bus.rx_count_0); end
  endtask

  task automatic test_rx_er();
    int errs;
    clr();
    arm(2'b01);
    send_frame(30, 8'h40, 10, 1'b0, 6);
    vectors++; if (wr_cnt0 !== 10) begin miscompares++; $display("FAIL er_wr0: got %0d want 10", wr_cnt0); end
    vectors++; if (done_log.size() !== 0) begin miscompares++; $display("FAIL er_done: got %0d pulses want 0", done_log.size()); end
    clr();
    send_frame(25, 8'h70, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 !== 25) begin miscompares++; $display("FAIL er_next_wr0: got %0d want 25", wr_cnt0); end
    errs = 0;
    for (int k = 0; k < 25; k++) if (mem0[k] !== 8'(8'h70 + 8'(k))) errs++;
    vectors++; if (errs !== 0) begin miscompares++; $display("FAIL er_next_data: got %0d bad bytes want 0", errs); end
    vectors++; if (done_cnt0 !== 1) begin miscompares++; $display("FAIL er_next_done: got %0d want 1", done_cnt0); end
    vectors++; if (bus.rx_count_0 !== 11'd25) begin miscompares++; $display("FAIL er_next_count0: got %0d want 25", bus.rx_count_0); end
  endtask

  task automatic test_max_len();
    int errs;
    clr();
    arm(2'b01);
    send_frame(2048, 8'h05, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 !== 2047) begin miscompares++; $display("FAIL over_wr0: got %0d want 2047", wr_cnt0); end
    vectors++; if (done_log.size() !== 0) begin miscompares++; $display("FAIL over_done: got %0d pulses want 0", done_log.size()); end
    vectors++; if (bus.rx_count_0 !== 11'd25) begin miscompares++; $display("FAIL over_count0: got %0d want 25", bus.rx_count_0); end
    clr();
    send_frame(2047, 8'hC1, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 !== 2047) begin miscompares++; $display("FAIL max_wr0: got %0d want 2047", wr_cnt0); end
    errs = 0;
    for (int k = 0; k < 2047; k++) if (mem0[k] !== 8'(8'hC1 + 8'(k))) errs++;
    vectors++; if (errs !== 0 || adr_err0 !== 0) begin miscompares++; $display("FAIL max_data: got %0d bad bytes %0d bad addresses want 0", errs, adr_err0); end
    vectors++; if (done_cnt0 !== 1) begin miscompares++; $display("FAIL max_done: got %0d want 1", done_cnt0); end
    vectors++; if (bus.rx_count_0 !== 11'd2047) begin miscompares++; $display("FAIL max_count0: got %0d want 2047", bus.rx_count_0); end
    clr();
    arm(2'b01);
    send_frame(30, 8'h99, -1, 1'b1, 6);
    vectors++; if (wr_cnt0 + wr_cnt1 !== 0) begin miscompares++; $display("FAIL bad_sfd_wr: got %0d writes want 0", wr_cnt0 + wr_cnt1); end
    vectors++; if (done_log.size() !== 0) begin miscompares++; $display("FAIL bad_sfd_done: got %0d pulses want 0", done_log.size()); end
    clr();
    send_frame(10, 8'h5A, -1, 1'b0, 6);
    vectors++; if (bus.rx_count_0 !== 11'd10 || done_cnt0 !== 1) begin miscompares++; $display("FAIL bad_sfd_still_armed: got count %0d done %0d want 10 and 1", bus.rx_count_0, done_cnt0); end
  endtask

  task automatic test_reset_mid();
    int errs;
    clr();
    arm(2'b01);
    tx_head(1'b0);
    for (int k = 0; k < 20; k++) tx_byte(8'(8'hE0 + 8'(k)), 1'b0);
    rst = 1'b1;
    tx_byte(8'hF4, 1'b0);
    @(negedge clk);
    vectors++; if (bus.rx_done !== 2'b00 || bus.rxb0_we !== 1'b0 || bus.rxb1_we !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl: got done %b we %b%b want 00 0 0", bus.rx_done, bus.rxb0_we, bus.rxb1_we); end
    vectors++; if (bus.rx_count_0 !== 11'd0 || bus.rx_count_1 !== 11'd0) begin miscompares++; $display("FAIL midrst_counts: got %0d %0d want 0 0", bus.rx_count_0, bus.rx_count_1); end
    vectors++; if (bus.rxb0_adr !== 11'd0 || bus.rxb0_dat !== 8'h00) begin miscompares++; $display("FAIL midrst_adr_dat: got %0d %h want 0 00", bus.rxb0_adr, bus.rxb0_dat); end
    clr();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tx_byte(8'(8'hF5 + 8'(k)), 1'b0);
    idle(6);
    vectors++; if (wr_cnt0 + wr_cnt1 !== 0 || done_log.size() !== 0) begin miscompares++; $display("FAIL midrst_tail: got %0d writes %0d done want 0 0", wr_cnt0 + wr_cnt1, done_log.size()); end
    send_frame(15, 8'h11, -1, 1'b0, 6);
    vectors++; if (wr_cnt0 + wr_cnt1 !== 0) begin miscompares++; $display("FAIL midrst_avail_cleared: got %0d writes want 0", wr_cnt0 + wr_cnt1); end
    clr();
    arm(2'b01);
    send_frame(12, 8'h3C, -1, 1'b0, 6);
    errs = 0;
    for (int k = 0; k < 12; k++) if (mem0[k] !== 8'(8'h3C + 8'(k))) errs++;
    vectors++; if (wr_cnt0 !== 12 || errs !== 0) begin miscompares++; $display("FAIL midrst_rearm_data: got %0d writes %0d bad bytes want 12 0", wr_cnt0, errs); end
    vectors++; if (done_cnt0 !== 1 || bus.rx_count_0 !== 11'd12) begin miscompares++; $display("FAIL midrst_rearm_done: got done %0d count %0d want 1 12", done_cnt0, bus.rx_count_0); end
  endtask

  initial begin
    clr();
    test_reset();
    test_single();
    test_back_to_back();
    test_unarmed();
    test_rx_er();
    test_max_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
